// File: rtl/rom_stream_reader.sv
// rom_stream_reader: command-driven sequencer for an async-read ROM.
// Takes a (base, stride, length) command, walks the ROM address with
// modulo-DEPTH wrap, and returns the words as a valid/ready stream that
// carries a last-beat flag. Sustains one beat per clock when the sink is
// always ready, and holds the beat stable while the sink stalls.
module rom_stream_reader #(
    parameter int WIDTH  = 5,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [ADDR_W-1:0] CMD_BASE,
    input  logic [ADDR_W-1:0] CMD_STRIDE,
    input  logic [CNT_W-1:0]  CMD_LEN,
    output logic [ADDR_W-1:0] RADDR,
    input  logic [WIDTH-1:0]  RDATA,
    output logic              O_VALID,
    input  logic              O_READY,
    output logic [WIDTH-1:0]  O_DATA,
    output logic              O_LAST,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // DEPTH fits in ADDR_W+1 bits. Every range compare uses this width.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_t             state_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [ADDR_W-1:0]  stride_reg;
    logic [CNT_W-1:0]   remaining_reg;
    logic [WIDTH-1:0]   o_data_reg;
    logic               o_valid_reg;
    logic               o_last_reg;
    logic               done_reg;
    logic               err_reg;

    logic               load;
    logic               last_load;
    logic               cmd_bad;
    logic [ADDR_W:0]    addr_sum;
    logic [ADDR_W:0]    addr_wrapped;
    logic [ADDR_W-1:0]  addr_next;

    // The output register can take a new word when it is empty or when its
    // current word leaves in this cycle. This gives a bubble-free stream.
    assign load      = !o_valid_reg || O_READY;
    assign last_load = (remaining_reg == CNT_W'(1));

    // A base or stride that lies outside the ROM makes the command invalid.
    assign cmd_bad = ({1'b0, CMD_BASE} >= DEPTH_W) || ({1'b0, CMD_STRIDE} >= DEPTH_W);

    // Next address is (addr + stride) mod DEPTH. The sum is one bit wider so
    // that a non-power-of-two DEPTH wraps correctly. The subtraction can
    // happen only once, because both operands are below DEPTH.
    assign addr_sum     = {1'b0, addr_reg} + {1'b0, stride_reg};
    assign addr_wrapped = addr_sum - DEPTH_W;
    assign addr_next    = (addr_sum >= DEPTH_W) ? addr_wrapped[ADDR_W-1:0]
                                                : addr_sum[ADDR_W-1:0];

    // Sequencer FSM together with the output register and the status pulses.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            stride_reg    <= '0;
            remaining_reg <= '0;
            o_data_reg    <= '0;
            o_valid_reg   <= 1'b0;
            o_last_reg    <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (CMD_VALID) begin
                        if (cmd_bad) begin
                            err_reg <= 1'b1;
                        end else if (CMD_LEN == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            addr_reg      <= CMD_BASE;
                            stride_reg    <= CMD_STRIDE;
                            remaining_reg <= CMD_LEN;
                            state_reg     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (load) begin
                        o_data_reg    <= RDATA;
                        o_valid_reg   <= 1'b1;
                        o_last_reg    <= last_load;
                        remaining_reg <= remaining_reg - CNT_W'(1);
                        addr_reg      <= addr_next;
                        if (last_load) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (o_valid_reg && O_READY) begin
                        o_valid_reg <= 1'b0;
                        o_last_reg  <= 1'b0;
                        done_reg    <= 1'b1;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign CMD_READY = (state_reg == IDLE);
    assign BUSY      = (state_reg != IDLE);
    assign RADDR     = addr_reg;
    assign O_VALID   = o_valid_reg;
    assign O_DATA    = o_data_reg;
    assign O_LAST    = o_last_reg;
    assign DONE      = done_reg;
    assign ERR       = err_reg;

endmodule

// File: doc/rom_stream_reader.md
# rom_stream_reader

Command-driven read sequencer that sits directly upstream of the read-only memory (async-read ROM, `sync_read` = 0). It accepts a (base, stride, length) command and drives the ROM read address. It captures the combinational read data and emits it as a valid/ready stream with a last-beat flag. It provides one beat per cycle under no backpressure and holds data stable under backpressure.

## Interface
- `WIDTH`, default 5: ROM data width.
- `DEPTH`, default 4: ROM word count, ≥ 2, not required to be a power of two.
- `ADDR_W`, default $clog2(DEPTH): address width, derived, never overridden.
- `CNT_W`, default 8: length field width.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `CMD_VALID`  in  1  command offered.
- `CMD_READY`  out  1  high only in IDLE.
- `CMD_BASE`  in  ADDR_W  first word address.
- `CMD_STRIDE`  in  ADDR_W  address increment per beat.
- `CMD_LEN`  in  CNT_W  number of beats; 0 is legal.
- `RADDR`  out  ADDR_W  to ROM read address.
- `RDATA`  in  WIDTH  from ROM; combinationally valid for current `RADDR`.
- `O_VALID`  out  1  stream beat valid.
- `O_READY`  in  1  downstream accepts.
- `O_DATA`  out  WIDTH  beat data.
- `O_LAST`  out  1  final beat of command.
- `BUSY`  out  1  state ≠ IDLE.
- `DONE`  out  1  one-cycle pulse when a command completes normally.
- `ERR`  out  1  one-cycle pulse when a command is rejected.

## Operation
- FSM has three states: IDLE, RUN and DRAIN. Registers: `addr`, `remaining`, `stride`, and the output register (`O_DATA`, `O_VALID`, `O_LAST`).
- IDLE:
  - A command is accepted on CMD_VALID & CMD_READY.
  - If `CMD_BASE` ≥ DEPTH or `CMD_STRIDE` ≥ DEPTH, the command is rejected: pulse ERR next cycle, stay in IDLE, emit no beats.
  - Else if `CMD_LEN` = 0: pulse DONE next cycle and stay in IDLE.
  - Else: load `addr` = base, `stride`, `remaining` = len, and go to RUN.
- RUN:
  - Define `load` = !O_VALID | O_READY.
  - On `load`, the output register takes O_DATA = RDATA, O_VALID = 1, and O_LAST = (remaining == 1).
  - Also on `load`: `remaining` decrements, and `addr` becomes (addr + stride) mod DEPTH. The sum is computed at ADDR_W+1 bits, minus DEPTH if ≥ DEPTH.
  - When the load with `remaining` = 1 occurs, go to DRAIN.
- DRAIN: when O_VALID & O_READY, clear O_VALID and O_LAST, pulse DONE next cycle, and go to IDLE.
- `RADDR` = `addr` register in all states.
- While O_VALID & !O_READY, O_DATA and O_LAST are held stable and `addr` does not advance.
- In RUN, when O_VALID & O_READY and `load` occur together, the old beat is consumed and the new beat is registered in the same edge. No bubble is inserted.
- CMD_VALID while BUSY is ignored, with no queuing.
- Reset values: state IDLE, `addr` 0, RADDR 0, O_VALID 0, O_DATA 0, O_LAST 0, DONE 0, ERR 0, BUSY 0, CMD_READY 1.
- RESET mid-command aborts immediately. The in-flight beat is dropped, and no DONE or ERR is generated.

## Timing
- Command accepted at cycle t; RUN at t+1 with RADDR = base.
- First O_VALID at t+2. With O_READY held high, beat k (0-based) is presented at t+2+k.
- Last beat is presented at t+1+LEN with O_LAST = 1. DONE = 1 and CMD_READY = 1 at t+2+LEN.
- Earliest next command is accepted at t+2+LEN.
- LEN = 0 or reject: DONE/ERR = 1 at t+1 and CMD_READY stays 1. The next command can be accepted at t+1.
- DONE and ERR are never both high, and each is high for exactly one cycle per command.
- Latency RADDR→O_DATA is one cycle, which relies on the ROM's combinational read.

## Test plan
All scenarios use ROM contents addr0..3 = 5, 0, 21, 11 (WIDTH 5, DEPTH 4) unless noted.
- **Linear read:** base 0, stride 1, len 4, O_READY = 1 → O_DATA 5, 0, 21, 11 at t+2..t+5, O_LAST only with 11, DONE at t+6.
- **Wrap and stride:**
  - base 3, stride 1, len 3 → 11, 5, 0.
  - base 1, stride 2, len 4 → 0, 11, 0, 11.
- **Backpressure:** base 2, stride 1, len 2; O_READY low for 3 cycles after first O_VALID → O_DATA holds 21 and RADDR holds 3. Then 21 and 11 are transferred on consecutive cycles, O_LAST is set with 11, and DONE follows.
- **Zero length and reject:**
  - len 0 → no O_VALID, DONE at t+1.
  - DEPTH = 3 build, base 3 → ERR at t+1, no beats, no DONE.
- **Reset mid-stream:** RESET asserted after 2 beats of a len-4 command → next cycle O_VALID 0, BUSY 0, CMD_READY 1, RADDR 0, no DONE. A following base 0, len 1 command yields 5 with O_LAST.
- **Busy command ignore:** CMD_VALID pulsed with different base during RUN → not accepted (CMD_READY 0). The original sequence completes unchanged.
